// File: rtl/vu_peak_meter.sv
// vu_peak_meter
//   Converts received offset-binary audio bytes into a VU meter display:
//   a thermometer bar of the latest sample magnitude, a peak-hold dot with
//   timed hold and stepped decay, and a stretched clip indicator.
//
// Ports
//   clk      system clock
//   rst_     asynchronous active-low reset
//   data_i   received sample byte, offset binary (0x80 = silence)
//   valid_i  single-cycle strobe, data_i valid this cycle
//   bar_o    thermometer bar of last sample magnitude, bit 0 = lowest
//   peak_o   one-hot peak-hold dot, all zero when peak is 0
//   clip_o   stretched clip indicator (full-scale sample seen)
//   busy_o   high while the peak FSM is holding or decaying
module vu_peak_meter #(
  parameter int unsigned LEDS         = 8,
  parameter int unsigned HOLD_CYCLES  = 2000000,
  parameter int unsigned DECAY_CYCLES = 250000,
  parameter int unsigned DECAY_STEP   = 8,
  parameter int unsigned CLIP_CYCLES  = 4000000
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [7:0]      data_i,
  input  logic            valid_i,
  output logic [LEDS-1:0] bar_o,
  output logic [LEDS-1:0] peak_o,
  output logic            clip_o,
  output logic            busy_o
);

  localparam int unsigned STEP    = 128 / LEDS;
  localparam int unsigned STEP_SH = $clog2(STEP);
  localparam int unsigned HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int unsigned DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam int unsigned CW = (CLIP_CYCLES  > 1) ? $clog2(CLIP_CYCLES)  : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DECAY} state_e;

  state_e          state_q, state_d;
  logic [6:0]      peak_q, peak_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DW-1:0]   decay_cnt_q, decay_cnt_d;
  logic [CW-1:0]   clip_cnt_q, clip_cnt_d;
  logic            clip_q, clip_d;
  logic [LEDS-1:0] bar_q, bar_d;

  logic [6:0]      mag;
  logic [LEDS-1:0] seg;
  logic [6:0]      peak_dec;
  logic [6:0]      peak_m1;
  logic            clip_hit;

  // Magnitude; 0x00 would be 128, saturate to 127.
  always_comb begin
    mag = '0;
    if (data_i[7]) begin
      mag = data_i[6:0];
    end else if (data_i == 8'h00) begin
      mag = 7'h7F;
    end else begin
      mag = 7'(8'h80 - data_i);
    end
  end

  always_comb begin
    seg = '0;
    for (int unsigned k = 0; k < LEDS; k++) begin
      seg[k] = (mag > 7'(k * STEP));
    end
  end

  // Dot index is ceil(peak/STEP)-1 == (peak-1)/STEP for peak > 0.
  always_comb begin
    peak_m1 = peak_q - 7'd1;
    peak_o  = '0;
    for (int unsigned k = 0; k < LEDS; k++) begin
      peak_o[k] = (peak_q != 7'd0) && ((peak_m1 >> STEP_SH) == 7'(k));
    end
  end

  assign peak_dec = (peak_q > 7'(DECAY_STEP)) ? (peak_q - 7'(DECAY_STEP)) : 7'd0;
  assign clip_hit = valid_i && ((data_i == 8'h00) || (data_i == 8'hFF));

  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = decay_cnt_q;
    if (valid_i && (mag > peak_q)) begin
      peak_d     = mag;
      hold_cnt_d = HW'(HOLD_CYCLES - 1);
      state_d    = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end else begin
            state_d     = ST_DECAY;
            decay_cnt_d = DW'(DECAY_CYCLES - 1);
          end
        end
        ST_DECAY: begin
          if (decay_cnt_q != '0) begin
            decay_cnt_d = decay_cnt_q - DW'(1);
          end else begin
            peak_d      = peak_dec;
            decay_cnt_d = DW'(DECAY_CYCLES - 1);
            if (peak_dec == 7'd0) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    clip_d     = clip_q;
    clip_cnt_d = clip_cnt_q;
    if (clip_hit) begin
      clip_cnt_d = CW'(CLIP_CYCLES - 1);
      clip_d     = 1'b1;
    end else if (clip_cnt_q == '0) begin
      clip_d = 1'b0;
    end else begin
      clip_cnt_d = clip_cnt_q - CW'(1);
    end
  end

  assign bar_d = valid_i ? seg : bar_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= ST_IDLE;
      peak_q      <= '0;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
      clip_cnt_q  <= '0;
      clip_q      <= 1'b0;
      bar_q       <= '0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      clip_cnt_q  <= clip_cnt_d;
      clip_q      <= clip_d;
      bar_q       <= bar_d;
    end
  end

  assign bar_o  = bar_q;
  assign clip_o = clip_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule
